axi_addr_burst_unpacker: RTL and testbench

Drains AXI address-channel entries from the 2-deep request FIFO, one entry at a time. It unpacks each entry's fields and expands the burst into a sequence of per-beat addresses (FIXED / INCR / WRAP). Each beat is presented to the slave-side data path over a valid/ready handshake. It sits on the slave side, between the address FIFO's read port and the memory/data-beat logic.

---
 rtl/axi_addr_burst_unpacker.sv | 96 +++++++++
 tb/tb_axi_addr_burst_unpacker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_addr_burst_unpacker.sv
// axi_addr_burst_unpacker: pops AXI address entries and expands each burst into per-beat addresses
module axi_addr_burst_unpacker #(
   parameter int tagbits = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fifo_empty,
   input  logic [tagbits+48:0] fifo_entry,
   output logic               fifo_read_en,
   output logic               beat_valid,
   input  logic               beat_ready,
   output logic [31:0]        beat_addr,
   output logic [tagbits-1:0] beat_id,
   output logic [1:0]         beat_size,
   output logic               beat_last,
   output logic               beat_err,
   output logic [2:0]         beat_prot,
   output logic               busy
);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_n;
   logic [3:0]  cnt;
   logic [1:0]  mode;
   logic        err_r;
   logic [31:0] lower;
   logic [7:0]  total;
   logic        accept;
   logic [31:0] ld_addr, ld_lower, inc, upper, nxt_addr;
   logic [3:0]  ld_len, ld_bytes, bytes;
   logic [1:0]  ld_size, ld_burst, ld_mode;
   logic [7:0]  ld_total;
   logic        ld_err;
   logic        unused_lock_cache;
   assign unused_lock_cache = ^fifo_entry[8:3];
   assign ld_addr  = fifo_entry[48:17];
   assign ld_len   = fifo_entry[16:13];
   assign ld_size  = fifo_entry[12:11];
   assign ld_burst = fifo_entry[10:9];
   assign ld_bytes = 4'd1 << ld_size;
   assign ld_total = ({4'd0, ld_len} + 8'd1) << ld_size;
   assign ld_lower = ld_addr & ~{24'd0, ld_total - 8'd1};
   // malformed bursts fall back to INCR but keep err flagged for every beat
   assign ld_err   = (ld_burst == 2'b11) ||
                     ((ld_burst == 2'b10) &&
                      (!(ld_len == 4'd1 || ld_len == 4'd3 || ld_len == 4'd7 || ld_len == 4'd15) ||
                       ((ld_addr[3:0] & (ld_bytes - 4'd1)) != 4'd0)));
   assign ld_mode  = ld_err ? 2'b01 : ld_burst;
   assign bytes    = 4'd1 << beat_size;
   assign inc      = (beat_addr & ~{28'd0, bytes - 4'd1}) + {28'd0, bytes};
   assign upper    = lower + {24'd0, total};
   assign nxt_addr = (mode == 2'b00) ? beat_addr :
                     (mode == 2'b10 && inc == upper) ? lower : inc;
   assign accept   = beat_valid && beat_ready;
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end
   always_comb begin
      state_n = state;
      if (fifo_read_en)          state_n = BURST;
      else if (accept && beat_last) state_n = IDLE;
   end
   always_comb begin
      beat_valid   = (state == BURST);
      beat_last    = (state == BURST) && (cnt == 4'd0);
      beat_err     = (state == BURST) && err_r;
      busy         = (state == BURST);
      fifo_read_en = rst && !fifo_empty && (state == IDLE || (accept && beat_last));
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         beat_addr <= '0;
         beat_id   <= '0;
         beat_size <= '0;
         beat_prot <= '0;
         cnt       <= '0;
         mode      <= '0;
         err_r     <= 1'b0;
         lower     <= '0;
         total     <= '0;
      end else if (fifo_read_en) begin
         beat_addr <= ld_addr;
         beat_id   <= fifo_entry[tagbits+48:49];
         beat_size <= ld_size;
         beat_prot <= fifo_entry[2:0];
         cnt       <= ld_len;
         mode      <= ld_mode;
         err_r     <= ld_err;
         lower     <= ld_lower;
         total     <= ld_total;
      end else if (accept) begin
         cnt       <= cnt - 4'd1;
         beat_addr <= nxt_addr;
      end
   end
endmodule

// File: tb/tb_axi_addr_burst_unpacker.sv
// tb_axi_addr_burst_unpacker: directed bench with a FIFO model and an expected-beat scoreboard
module tb_axi_addr_burst_unpacker;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [50:0] fifo_entry = '0;
   logic        fifo_read_en, beat_valid, beat_last, beat_err, busy;
   logic        beat_ready = 1'b0;
   logic [31:0] beat_addr;
   logic [1:0]  beat_id, beat_size;
   logic [2:0]  beat_prot;
   typedef struct {
      logic [31:0] a;
      logic [1:0]  id;
      logic [1:0]  sz;
      logic [2:0]  pr;
      logic        l;
      logic        e;
   } beat_t;
   beat_t       sb[$];
   logic [50:0] fq[$];
   int          n_cmp = 0, n_bad = 0;
   logic        last_rd, last_valid, stall_p = 1'b0;
   logic [31:0] p_addr;
   logic [1:0]  p_id;
   logic        p_last, p_err;
   axi_addr_burst_unpacker #(.tagbits(2)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_entry(fifo_entry),
      .fifo_read_en(fifo_read_en), .beat_valid(beat_valid), .beat_ready(beat_ready),
      .beat_addr(beat_addr), .beat_id(beat_id), .beat_size(beat_size),
      .beat_last(beat_last), .beat_err(beat_err), .beat_prot(beat_prot), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [50:0] mk(input logic [1:0] id, input logic [31:0] a, input logic [3:0] len,
                                      input logic [1:0] sz, input logic [1:0] bt, input logic [2:0] pr);
      return {id, a, len, sz, bt, 2'b00, 4'b0000, pr};
   endfunction
   // reference expansion written arithmetically, independent of the RTL masking
   function automatic void gen(input logic [50:0] en);
      logic [31:0] a = en[48:17];
      int    len = int'(en[16:13]);
      int    sz  = int'(en[12:11]);
      int    bt  = int'(en[10:9]);
      longint by = longint'(1) << sz;
      longint tot = longint'(len + 1) * by;
      longint lo, x;
      bit    err;
      beat_t b;
      err = (bt == 3) || (bt == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
            (bt == 2 && (longint'(a) % by) != 0);
      for (int i = 0; i <= len; i++) begin
         if (bt == 0) x = longint'(a);
         else if (bt == 2 && !err) begin
            lo = longint'(a) - longint'(a) % tot;
            x  = lo + (longint'(a) - lo + i * by) % tot;
         end else x = (i == 0) ? longint'(a) : ((longint'(a) / by) + i) * by;
         b.a = x[31:0]; b.id = en[50:49]; b.sz = en[12:11]; b.pr = en[2:0];
         b.l = (i == len); b.e = err;
         sb.push_back(b);
      end
   endfunction
   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_entry = (fq.size() == 0) ? '0 : fq[0];
   endtask
   task automatic push(input logic [50:0] en);
      fq.push_back(en);
      gen(en);
      refresh();
   endtask
   task automatic cyc(input logic rdy);
      logic dp;
      beat_t e;
      beat_ready = rdy;
      @(negedge clk);
      last_rd = fifo_read_en;
      last_valid = beat_valid;
      if (stall_p) begin
         chk("hold_valid", beat_valid, 1);
         chk("hold_addr", beat_addr, p_addr);
         chk("hold_id", beat_id, p_id);
         chk("hold_last", beat_last, p_last);
         chk("hold_err", beat_err, p_err);
      end
      if (beat_valid && beat_ready) begin
         if (sb.size() == 0) chk("extra_beat", beat_addr, 32'hx);
         else begin
            e = sb.pop_front();
            chk("addr", beat_addr, e.a);
            chk("id", beat_id, e.id);
            chk("size", beat_size, e.sz);
            chk("prot", beat_prot, e.pr);
            chk("last", beat_last, e.l);
            chk("err", beat_err, e.e);
         end
      end
      stall_p = beat_valid && !beat_ready;
      p_addr = beat_addr; p_id = beat_id; p_last = beat_last; p_err = beat_err;
      dp = fifo_read_en;
      @(posedge clk);
      #1;
      if (dp && fq.size() > 0) begin
         fq.delete(0);
         refresh();
      end
   endtask
   task automatic drain(input string tag);
      int k = 0;
      while (sb.size() > 0 && k < 200) begin
         cyc(1'b1);
         k++;
      end
      chk({tag, "_drain"}, sb.size(), 0);
      cyc(1'b1);
      chk({tag, "_idle"}, last_valid, 0);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, beat_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_last"}, beat_last, 0);
      chk({tag, "_err"}, beat_err, 0);
      chk({tag, "_addr"}, beat_addr, 0);
      chk({tag, "_id"}, beat_id, 0);
      chk({tag, "_size"}, beat_size, 0);
      chk({tag, "_prot"}, beat_prot, 0);
      chk({tag, "_rd"}, fifo_read_en, 0);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      // reset mid-burst, with a second entry waiting that must not be popped during reset
      push(mk(2'd1, 32'h1000, 4'd7, 2'd2, 2'b01, 3'd5));
      push(mk(2'd3, 32'h6002, 4'd2, 2'd1, 2'b11, 3'd2));
      cyc(1'b1);
      chk("lat_rd", last_rd, 1);
      chk("lat_valid", last_valid, 0);
      repeat (3) cyc(1'b1);
      chk("mid_sb", sb.size(), 8);
      beat_ready = 1'b0;
      rst = 1'b0;
      stall_p = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk_zero("midrst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      foreach (fq[i]) gen(fq[i]);
      drain("reserved");
      // INCR with an unaligned start
      push(mk(2'd0, 32'h1003, 4'd3, 2'd2, 2'b01, 3'd0));
      cyc(1'b1);
      chk("incr_lat_rd", last_rd, 1);
      cyc(1'b1);
      chk("incr_lat_valid", last_valid, 1);
      drain("incr");
      // WRAP
      push(mk(2'd1, 32'h2008, 4'd3, 2'd2, 2'b10, 3'd1));
      drain("wrap");
      // FIXED under backpressure
      push(mk(2'd2, 32'h3000, 4'd2, 2'd0, 2'b00, 3'd3));
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b1);
      cyc(1'b1);
      chk("fixed_cnt", sb.size(), 0);
      drain("fixed");
      // back-to-back: second entry is WRAP with an illegal length
      push(mk(2'd0, 32'h4000, 4'd1, 2'd2, 2'b01, 3'd4));
      push(mk(2'd3, 32'h5000, 4'd2, 2'd2, 2'b10, 3'd6));
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      chk("b2b_pop", last_rd, 1);
      cyc(1'b1);
      chk("b2b_valid", last_valid, 1);
      drain("b2b");
      // misaligned WRAP followed by a legal 16-beat WRAP of doublewords
      push(mk(2'd1, 32'h7002, 4'd3, 2'd2, 2'b10, 3'd0));
      push(mk(2'd2, 32'h8040, 4'd15, 2'd3, 2'b10, 3'd7));
      drain("wrap16");
      // address rollover
      push(mk(2'd0, 32'hFFFF_FFFC, 4'd1, 2'd2, 2'b01, 3'd0));
      drain("roll");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
